// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word width, multiplier counter width and FSM states.
package cpu_pkg;

  localparam int WORD_W    = 32;
  localparam int MUL_CNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/cla_add32.sv
// Carry-lookahead adder built from chained 4-bit lookahead groups; WIDTH must be a multiple of 4.
module cla_add32
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP = WIDTH / 4;

  logic [NGRP:0] gc;

  assign gc[0] = cin;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a[4*gi +: 4] & b[4*gi +: 4];
    assign p    = a[4*gi +: 4] ^ b[4*gi +: 4];
    assign c[0] = gc[gi];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum[4*gi +: 4] = p ^ c[3:0];
    assign gc[gi+1]       = c[4];
  end

  assign cout = gc[NGRP];

endmodule

// File: rtl/booth_mul32.sv
// Sequential signed radix-2 Booth multiplier, one add/shift step per cycle through cla_add32.
// Optional overflow flag output enabled by defining BOOTH_MUL_OVF_EN.
module booth_mul32
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
`ifdef BOOTH_MUL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  mul_state_t       state;
  mul_state_t       state_next;
  logic             busy_next;
  logic             done_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic             q_m1;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             sgn;
  logic             last_step;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] q_shift;

  // Booth operand select: add M, subtract M (two's complement), or pass A through.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case ({q_reg[0], q_m1})
      2'b01: begin
        add_b   = m_reg;
        add_cin = 1'b0;
      end
      2'b10: begin
        add_b   = ~m_reg;
        add_cin = 1'b1;
      end
      default: begin
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  cla_add32 #(.WIDTH(WIDTH)) u_add (
    .a    (acc),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (sum),
    .cout (cout)
  );

  // The true sign survives the add even when the sum overflows (e.g. M = most-negative).
  assign sgn       = acc[WIDTH-1] ^ add_b[WIDTH-1] ^ cout;
  assign acc_shift = {sgn, sum[WIDTH-1:1]};
  assign q_shift   = {sum[0], q_reg[WIDTH-1:1]};
  assign last_step = (count == CNT_W'(WIDTH - 1));

  // State register together with registered busy/done flags.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (last_step) state_next = DONE;
        else           state_next = RUN;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags line up with it once registered.
  always_comb begin
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  // Datapath: operand capture, Booth add/shift steps and product capture on the final step.
  always_ff @(posedge clock) begin
    if (clear) begin
      acc        <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      q_m1       <= 1'b0;
      count      <= '0;
      product_hi <= '0;
      product_lo <= '0;
`ifdef BOOTH_MUL_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            q_reg <= multiplier;
            q_m1  <= 1'b0;
            m_reg <= multiplicand;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_shift;
          q_reg <= q_shift;
          q_m1  <= q_reg[0];
          count <= count + CNT_W'(1);
          if (last_step) begin
            product_hi <= acc_shift;
            product_lo <= q_shift;
`ifdef BOOTH_MUL_OVF_EN
            ovf        <= (acc_shift != {WIDTH{q_shift[WIDTH-1]}});
`endif
          end
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_mul32.md
# booth_mul32

Sequential signed 32×32 multiplier using the radix-2 Booth algorithm, producing a 64-bit product in registers HI/LO. Sits directly upstream of the 32-bit carry-lookahead adder. Each cycle it drives the adder's operands and carry-in, then consumes the sum and carry-out to update its accumulator. It serves the datapath's MUL instruction; the control unit pulses `start` and waits for `done`.

## Interface
- `WIDTH`, default 32: operand width. The counter and the adder are sized from it; 32 is the only verified value.
- `clock`  in  1  rising-edge clock.
- `clear`  in  1  reset: synchronous and active-high.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `multiplicand`  in  WIDTH  signed M; sampled on the accepting edge.
- `multiplier`  in  WIDTH  signed Q; sampled on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; product valid.
- `product_hi`  out  WIDTH  upper half of the signed product.
- `product_lo`  out  WIDTH  lower half of the signed product.
- `ovf`  out  1  present only with `BOOTH_MUL_OVF_EN` (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when `count == WIDTH-1`.
  - DONE → IDLE unconditionally.
- Internal registers:
  - A: WIDTH-bit accumulator.
  - Q: WIDTH-bit multiplier.
  - `q_m1`: 1 bit.
  - M: WIDTH-bit multiplicand.
  - `count`: $clog2(WIDTH) bits.
- Accept (IDLE and `start`):
  - A←0, Q←`multiplier`, `q_m1`←0, M←`multiplicand`, `count`←0.
- Each RUN cycle, select on `{Q[0], q_m1}`:
  - 01 → add: B=M, cin=0.
  - 10 → subtract: B=~M, cin=1.
  - 00 or 11 → B=0, cin=0.
- Adder result: S = A + B + cin (WIDTH bits) with carry-out `cout`.
- True sign of the result: `sgn = A[W-1] ^ B[W-1] ^ cout`. This is correct even when M = 0x80000000.
- Arithmetic shift right: `{A, Q, q_m1} ← {sgn, S, Q}`. `count` increments.
- DONE: `product_hi`←A, `product_lo`←Q. These are loaded on the RUN→DONE edge.
- Product registers hold their value until the next RUN→DONE edge. They are not disturbed by a new start.
- `start` is ignored in RUN and DONE. It is not queued.
- Signed × signed only. Unsigned operands are out of scope.

## Timing
- Reset: while `clear` is high at an edge, all of the following go to 0, overriding everything:
  - state → IDLE.
  - `busy`, `done`, `product_hi`, `product_lo`, `ovf` → 0.
  - A, Q, M, `count`, `q_m1` → 0.
- `clear` in mid-RUN aborts the operation. No `done` is produced.
- Start accepted at edge t:
  - `busy` = 1 in cycles t+1 … t+WIDTH.
  - `done` = 1 in cycle t+WIDTH+1 only.
- Latency: WIDTH+1 cycles from the accepting edge to `done` (33 for WIDTH=32).
- Earliest next accept is the edge at the end of the `done` cycle+1. The module is back in IDLE then, so throughput is one multiply per WIDTH+2 cycles.
- `busy` and `done` are never high together.
- `busy` and `done` are registered, with no combinational path from inputs.
- Adder path: the adder is purely combinational, within one cycle. The critical path is operand mux → CLA → sign logic → A register.

## Configuration
- `BOOTH_MUL_OVF_EN` defined:
  - The `ovf` output exists.
  - On the RUN→DONE edge, `ovf`←1 if `product_hi` is not all copies of `product_lo[W-1]`, i.e. the product does not fit in WIDTH signed bits. Otherwise `ovf`←0.
  - `ovf` holds with the product registers and is cleared by `clear`.
- `BOOTH_MUL_OVF_EN` undefined:
  - No `ovf` port and no comparison logic.
  - All other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds:
  - `WORD_W` = 32.
  - The `mul_state_t` enum {IDLE, RUN, DONE}.
  - `MUL_CNT_W` = $clog2(WORD_W).
- Sub-module `cla_add32`:
  - Ports: a, b, cin → sum, cout.
  - It is the team's 32-bit carry-lookahead adder, 4-bit CLA groups chained.
  - Instantiated once. Its carry-out must be exposed for `sgn`.
- FSM, operand mux, shift registers and counter live in `booth_mul32` itself.

## Test plan
- 6 × 7 → `done` 33 cycles after start; HI=0x00000000, LO=0x0000002A; `ovf`=0.
- 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; `ovf`=0.
- 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000; `ovf`=1.
- 0x80000000 × 0xFFFFFFFF (−1) → HI=0x00000000, LO=0x80000000; `ovf`=1. This checks `sgn` at the most-negative M.
- Start 6×7, assert `clear` at cycle 10 → all outputs 0 next cycle; no `done`. A fresh start of 2×3 then gives LO=6.
- Start 6×7, pulse `start` with 9×9 at cycle 5 and in the `done` cycle → both ignored; result 42; `busy` low after `done`. Products hold 42 until the next completion.
